// File: rtl/pr_range_fetch.sv
// pr_range_fetch: walks an element range [req_start, req_end) one memory line at a
// time. Each line is read from memory, held, then offered to a downstream read buffer
// together with the valid element window (buf_base .. buf_bounds) inside that line.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          range request handshake
//   req_start, req_end           first element (inclusive), last element (exclusive)
//   mem_req/mem_req_ready        line read request handshake, mem_addr = line index
//   mem_rvalid, mem_rdata        returned line
//   buf_load                     one-cycle load strobe to the read buffer
//   buf_data/buf_base/buf_bounds held line and its valid element window
//   buf_busy                     downstream buffer still holds elements
//   done                         one-cycle completion pulse
//   lines_issued                 count of accepted line reads (wraps)
module pr_range_fetch #(
  parameter int unsigned FULL_WIDTH = 512,
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned IDX_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [IDX_WIDTH-1:0]  req_start,
  input  logic [IDX_WIDTH-1:0]  req_end,
  output logic                  mem_req,
  input  logic                  mem_req_ready,
  output logic [IDX_WIDTH-1:0]  mem_addr,
  input  logic                  mem_rvalid,
  input  logic [FULL_WIDTH-1:0] mem_rdata,
  output logic                  buf_load,
  output logic [FULL_WIDTH-1:0] buf_data,
  output logic [7:0]            buf_base,
  output logic [7:0]            buf_bounds,
  input  logic                  buf_busy,
  output logic                  done,
  output logic [15:0]           lines_issued
);

  localparam int unsigned MAX_ELEMS  = FULL_WIDTH / WIDTH;
  localparam int unsigned OFF_W      = $clog2(MAX_ELEMS);
  localparam logic [7:0]  FULL_BOUND = 8'(MAX_ELEMS);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitData, StDeliver} state_e;

  state_e                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    cur_line_q, last_line_q;
  logic [7:0]              first_off_q, last_end_q;
  logic                    is_first_q;
  logic [FULL_WIDTH-1:0]   hold_q;
  logic                    done_q;
  logic [15:0]             lines_q;

  logic                    nonempty;
  logic                    accept_range;
  logic                    accept_empty;
  logic                    last_line_hit;
  logic [IDX_WIDTH-1:0]    end_m1;

  assign nonempty      = req_end > req_start;
  assign accept_range  = req_valid && req_ready && nonempty;
  assign accept_empty  = req_valid && req_ready && !nonempty;
  // Only evaluated for non-empty requests, so req_end >= 1 and this never wraps.
  assign end_m1        = req_end - IDX_WIDTH'(1);
  assign last_line_hit = cur_line_q == last_line_q;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    buf_load  = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid && nonempty) state_d = StIssue;
      end
      StIssue: begin
        mem_req = 1'b1;
        if (mem_req_ready) state_d = StWaitData;
      end
      StWaitData: begin
        if (mem_rvalid) state_d = StDeliver;
      end
      StDeliver: begin
        if (!buf_busy) begin
          buf_load = 1'b1;
          state_d  = last_line_hit ? StIdle : StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_line_q  <= '0;
      last_line_q <= '0;
      first_off_q <= '0;
      last_end_q  <= '0;
      is_first_q  <= 1'b0;
      hold_q      <= '0;
      done_q      <= 1'b0;
      lines_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= accept_empty || (buf_load && last_line_hit);
      if (accept_range) begin
        cur_line_q  <= req_start >> OFF_W;
        last_line_q <= end_m1 >> OFF_W;
        first_off_q <= 8'(req_start[OFF_W-1:0]);
        last_end_q  <= 8'(end_m1[OFF_W-1:0]) + 8'd1;
        is_first_q  <= 1'b1;
      end else if (buf_load && !last_line_hit) begin
        // Advance only when another line remains, so cur_line never passes last_line.
        cur_line_q <= cur_line_q + IDX_WIDTH'(1);
        is_first_q <= 1'b0;
      end
      if (mem_req && mem_req_ready) lines_q <= lines_q + 16'd1;
      if (state_q == StWaitData && mem_rvalid) hold_q <= mem_rdata;
    end
  end

  // Address comes straight from cur_line, which cannot change while in StIssue.
  assign mem_addr     = cur_line_q;
  assign buf_data     = hold_q;
  assign buf_base     = is_first_q ? first_off_q : 8'd0;
  assign buf_bounds   = last_line_hit ? last_end_q : FULL_BOUND;
  assign done         = done_q;
  assign lines_issued = lines_q;

endmodule

// File: tb/tb_pr_range_fetch.sv
module tb_pr_range_fetch;
  localparam int unsigned FW = 512;
  localparam int unsigned IW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_start = '0;
  logic [IW-1:0] req_end = '0;
  logic          mem_req;
  logic          mem_req_ready = 1'b1;
  logic [IW-1:0] mem_addr;
  logic          mem_rvalid = 1'b0;
  logic [FW-1:0] mem_rdata = '0;
  logic          buf_load;
  logic [FW-1:0] buf_data;
  logic [7:0]    buf_base;
  logic [7:0]    buf_bounds;
  logic          buf_busy = 1'b0;
  logic          done;
  logic [15:0]   lines_issued;

  pr_range_fetch #(.FULL_WIDTH(512), .WIDTH(64), .IDX_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_start(req_start), .req_end(req_end), .mem_req(mem_req),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .buf_load(buf_load), .buf_data(buf_data),
    .buf_base(buf_base), .buf_bounds(buf_bounds), .buf_busy(buf_busy), .done(done),
    .lines_issued(lines_issued)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int exp_lines = 0;

  // Results of the last run_req call.
  int            n_rd, n_ld, n_done, ld_cyc, last_ld, done_cyc, rv_cyc;
  int            stall_seen, addr_change, busy_viol;
  logic          ready_at_req;
  logic [IW-1:0] rd_addr [8];
  logic [7:0]    ld_base [8];
  logic [7:0]    ld_bnd [8];
  logic [FW-1:0] ld_data [8];

  function automatic logic [FW-1:0] line_data(input logic [IW-1:0] a);
    return {16{a ^ 32'hA5C3_0000}};
  endfunction

  // Drives one request and acts as memory (1-cycle read latency) and downstream buffer.
  // stall: cycles mem_req_ready is held low on the first read.
  // busy:  cycles buf_busy is held high once the first line reaches DELIVER.
  task automatic run_req(input logic [IW-1:0] s, input logic [IW-1:0] e,
                         input int stall, input int busy);
    int            stall_left;
    int            busy_left;
    logic          pend;
    logic [IW-1:0] pend_addr;
    logic          prev_stalled;
    logic [IW-1:0] prev_addr;
    stall_left = stall; busy_left = 0; pend = 1'b0; pend_addr = '0;
    prev_stalled = 1'b0; prev_addr = '0;
    n_rd = 0; n_ld = 0; n_done = 0; ld_cyc = -1; last_ld = -1; done_cyc = -1; rv_cyc = -1;
    stall_seen = 0; addr_change = 0; busy_viol = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_start = s; req_end = e;
    #1 ready_at_req = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      buf_busy = busy_left > 0;
      if (busy_left > 0) busy_left--;
      mem_req_ready = stall_left == 0;
      mem_rvalid = pend;
      mem_rdata = pend ? line_data(pend_addr) : '0;
      if (pend) begin
        if (rv_cyc < 0) begin
          rv_cyc = cyc;
          busy_left = busy;
        end
        pend = 1'b0;
      end
      #1;
      if (prev_stalled && (!mem_req || mem_addr !== prev_addr)) addr_change++;
      prev_stalled = 1'b0;
      if (mem_req) begin
        if (mem_req_ready) begin
          if (n_rd < 8) rd_addr[n_rd] = mem_addr;
          n_rd++;
          pend = 1'b1;
          pend_addr = mem_addr;
        end else begin
          stall_left--;
          stall_seen++;
          prev_stalled = 1'b1;
          prev_addr = mem_addr;
        end
      end
      if (buf_load) begin
        if (buf_busy) busy_viol++;
        if (n_ld < 8) begin
          ld_base[n_ld] = buf_base; ld_bnd[n_ld] = buf_bounds; ld_data[n_ld] = buf_data;
        end
        if (n_ld == 0) ld_cyc = cyc;
        last_ld = cyc;
        n_ld++;
      end
      if (done) begin
        if (n_done == 0) done_cyc = cyc;
        n_done++;
      end
      if (n_done > 0 && cyc >= done_cyc + 2) break;
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0; buf_busy = 1'b0; mem_req_ready = 1'b1;
  endtask

  task automatic test_reset;
    #12;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_checks++; if (buf_load !== 1'b0) begin n_fail++; $display("FAIL reset_buf_load: got %b want 0", buf_load); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (lines_issued !== 16'd0) begin n_fail++; $display("FAIL reset_lines: got %0d want 0", lines_issued); end
    n_checks++; if (buf_base !== 8'd0) begin n_fail++; $display("FAIL reset_base: got %0d want 0", buf_base); end
    n_checks++; if (buf_bounds !== 8'd0) begin n_fail++; $display("FAIL reset_bounds: got %0d want 0", buf_bounds); end
    n_checks++; if (buf_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", buf_data); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_line;
    run_req(32'd3, 32'd6, 0, 0);
    exp_lines += 1;
    n_checks++; if (ready_at_req !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", ready_at_req); end
    n_checks++; if (n_rd !== 1) begin n_fail++; $display("FAIL single_nrd: got %0d want 1", n_rd); end
    n_checks++; if (rd_addr[0] !== 32'd0) begin n_fail++; $display("FAIL single_addr: got %0h want 0", rd_addr[0]); end
    n_checks++; if (n_ld !== 1) begin n_fail++; $display("FAIL single_nld: got %0d want 1", n_ld); end
    n_checks++; if (ld_base[0] !== 8'd3) begin n_fail++; $display("FAIL single_base: got %0d want 3", ld_base[0]); end
    n_checks++; if (ld_bnd[0] !== 8'd6) begin n_fail++; $display("FAIL single_bounds: got %0d want 6", ld_bnd[0]); end
    n_checks++; if (ld_data[0] !== line_data(32'd0)) begin n_fail++; $display("FAIL single_data: got %0h want %0h", ld_data[0], line_data(32'd0)); end
    n_checks++; if (done_cyc !== ld_cyc + 1) begin n_fail++; $display("FAIL single_done_cyc: got %0d want %0d", done_cyc, ld_cyc + 1); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL single_done_len: got %0d want 1", n_done); end
    n_checks++; if (lines_issued !== 16'(exp_lines)) begin n_fail++; $display("FAIL single_lines: got %0d want %0d", lines_issued, exp_lines); end
  endtask

  task automatic test_multi_line;
    logic [7:0] eb [3];
    logic [7:0] ebd [3];
    eb = '{8'd5, 8'd0, 8'd0};
    ebd = '{8'd8, 8'd8, 8'd5};
    run_req(32'd5, 32'd21, 0, 0);
    exp_lines += 3;
    n_checks++; if (n_rd !== 3) begin n_fail++; $display("FAIL multi_nrd: got %0d want 3", n_rd); end
    n_checks++; if (n_ld !== 3) begin n_fail++; $display("FAIL multi_nld: got %0d want 3", n_ld); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rd_addr[i] !== IW'(i)) begin n_fail++; $display("FAIL multi_addr[%0d]: got %0h want %0h", i, rd_addr[i], i); end
      n_checks++; if (ld_base[i] !== eb[i]) begin n_fail++; $display("FAIL multi_base[%0d]: got %0d want %0d", i, ld_base[i], eb[i]); end
      n_checks++; if (ld_bnd[i] !== ebd[i]) begin n_fail++; $display("FAIL multi_bounds[%0d]: got %0d want %0d", i, ld_bnd[i], ebd[i]); end
      n_checks++; if (ld_data[i] !== line_data(IW'(i))) begin n_fail++; $display("FAIL multi_data[%0d]: got %0h want %0h", i, ld_data[i], line_data(IW'(i))); end
    end
    n_checks++; if (done_cyc !== last_ld + 1) begin n_fail++; $display("FAIL multi_done_cyc: got %0d want %0d", done_cyc, last_ld + 1); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL multi_done_len: got %0d want 1", n_done); end
    n_checks++; if (lines_issued !== 16'(exp_lines)) begin n_fail++; $display("FAIL multi_lines: got %0d want %0d", lines_issued, exp_lines); end
  endtask

  task automatic test_empty;
    run_req(32'd8, 32'd8, 0, 0);
    n_checks++; if (n_rd !== 0) begin n_fail++; $display("FAIL empty_nrd: got %0d want 0", n_rd); end
    n_checks++; if (done_cyc !== 0) begin n_fail++; $display("FAIL empty_done_cyc: got %0d want 0", done_cyc); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL empty_done_len: got %0d want 1", n_done); end
    run_req(32'd10, 32'd4, 0, 0);
    n_checks++; if (n_rd !== 0) begin n_fail++; $display("FAIL reversed_nrd: got %0d want 0", n_rd); end
    n_checks++; if (done_cyc !== 0) begin n_fail++; $display("FAIL reversed_done_cyc: got %0d want 0", done_cyc); end
    n_checks++; if (lines_issued !== 16'(exp_lines)) begin n_fail++; $display("FAIL empty_lines: got %0d want %0d", lines_issued, exp_lines); end
  endtask

  task automatic test_busy_hold;
    run_req(32'd0, 32'd8, 0, 10);
    exp_lines += 1;
    n_checks++; if (n_ld !== 1) begin n_fail++; $display("FAIL busy_nld: got %0d want 1", n_ld); end
    n_checks++; if (busy_viol !== 0) begin n_fail++; $display("FAIL busy_overlap: got %0d want 0", busy_viol); end
    n_checks++; if (ld_cyc !== rv_cyc + 11) begin n_fail++; $display("FAIL busy_ld_cyc: got %0d want %0d", ld_cyc, rv_cyc + 11); end
    n_checks++; if (ld_bnd[0] !== 8'd8) begin n_fail++; $display("FAIL busy_bounds: got %0d want 8", ld_bnd[0]); end
  endtask

  task automatic test_stall;
    run_req(32'd16, 32'd24, 5, 0);
    exp_lines += 1;
    n_checks++; if (stall_seen !== 5) begin n_fail++; $display("FAIL stall_cycles: got %0d want 5", stall_seen); end
    n_checks++; if (addr_change !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d want 0", addr_change); end
    n_checks++; if (n_rd !== 1) begin n_fail++; $display("FAIL stall_nrd: got %0d want 1", n_rd); end
    n_checks++; if (rd_addr[0] !== 32'd2) begin n_fail++; $display("FAIL stall_addr: got %0h want 2", rd_addr[0]); end
    n_checks++; if (lines_issued !== 16'(exp_lines)) begin n_fail++; $display("FAIL stall_lines: got %0d want %0d", lines_issued, exp_lines); end
  endtask

  task automatic test_max_end;
    run_req(32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0);
    exp_lines += 1;
    n_checks++; if (n_rd !== 1) begin n_fail++; $display("FAIL maxend_nrd: got %0d want 1", n_rd); end
    n_checks++; if (rd_addr[0] !== 32'h1FFF_FFFF) begin n_fail++; $display("FAIL maxend_addr: got %0h want 1fffffff", rd_addr[0]); end
    n_checks++; if (ld_base[0] !== 8'd5) begin n_fail++; $display("FAIL maxend_base: got %0d want 5", ld_base[0]); end
    n_checks++; if (ld_bnd[0] !== 8'd7) begin n_fail++; $display("FAIL maxend_bounds: got %0d want 7", ld_bnd[0]); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL maxend_done: got %0d want 1", n_done); end
  endtask

  task automatic test_reset_mid;
    int loads;
    int not_ready;
    @(posedge clk); #1;
    req_valid = 1'b1; req_start = 32'd0; req_end = 32'd8; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_issue: got %b want 1", mem_req); end
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", req_ready); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", req_ready); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_mem_req: got %b want 0", mem_req); end
    n_checks++; if (lines_issued !== 16'd0) begin n_fail++; $display("FAIL rmid_lines: got %0d want 0", lines_issued); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = line_data(32'd7);
    loads = 0; not_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (buf_load) loads++;
      if (!req_ready) not_ready++;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    n_checks++; if (loads !== 0) begin n_fail++; $display("FAIL rmid_late_load: got %0d want 0", loads); end
    n_checks++; if (not_ready !== 0) begin n_fail++; $display("FAIL rmid_idle: got %0d want 0", not_ready); end
    n_checks++; if (buf_data !== '0) begin n_fail++; $display("FAIL rmid_data: got %0h want 0", buf_data); end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_multi_line();
    test_empty();
    test_busy_hold();
    test_stall();
    test_max_end();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pr_range_fetch.md
PR_RANGE_FETCH -- requirements
Module: pr_range_fetch

Interface
REQ-001 Parameter FULL_WIDTH, default 512, SHALL set the memory line width in bits.
REQ-002 Parameter WIDTH, default 64, SHALL set the element width in bits; MAX_ELEMS = FULL_WIDTH/WIDTH, a power of two, default 8.
REQ-003 Parameter IDX_WIDTH, default 32, SHALL set the width of element indices and of the line address.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1, SHALL be an asynchronous, active-low reset.
REQ-006 Port req_valid, input, 1, SHALL mark a valid range request.
REQ-007 Port req_ready, output, 1, SHALL be high when a request can be accepted.
REQ-008 Port req_start, input, IDX_WIDTH, SHALL give the first element index, inclusive.
REQ-009 Port req_end, input, IDX_WIDTH, SHALL give the last element index, exclusive.
REQ-010 Port mem_req, output, 1, SHALL mark a valid line read request.
REQ-011 Port mem_req_ready, input, 1, SHALL mark that memory accepts the request.
REQ-012 Port mem_addr, output, IDX_WIDTH, SHALL carry the line index (element index >> log2(MAX_ELEMS)).
REQ-013 Port mem_rvalid, input, 1, SHALL mark returned line data.
REQ-014 Port mem_rdata, input, FULL_WIDTH, SHALL carry the returned line.
REQ-015 Port buf_load, output, 1, SHALL be a one-cycle load strobe to the downstream read buffer.
REQ-016 Port buf_data, output, FULL_WIDTH, SHALL carry the held line.
REQ-017 Port buf_base, output, 8, SHALL give the first valid element offset in the line.
REQ-018 Port buf_bounds, output, 8, SHALL give the exclusive end offset in the line.
REQ-019 Port buf_busy, input, 1, SHALL be the downstream buffer's "elements remain" flag.
REQ-020 Port done, output, 1, SHALL pulse for one cycle when a request completes.
REQ-021 Port lines_issued, output, 16, SHALL count line reads accepted since reset, wrapping at 2^16.

Function
REQ-022 The FSM SHALL use states IDLE, ISSUE, WAIT_DATA, DELIVER.
REQ-023 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-024 On req_valid && req_ready with req_end > req_start, the FSM SHALL latch cur_line = req_start>>3, last_line = (req_end-1)>>3, first offset req_start[2:0] and last end offset ((req_end-1)&7)+1, and go to ISSUE.
REQ-025 On an accepted request with req_end <= req_start, the block SHALL issue no read, pulse done the next cycle and stay in IDLE.
REQ-026 In ISSUE, mem_req SHALL be 1 with mem_addr = cur_line; on mem_req_ready, the FSM SHALL go to WAIT_DATA and increment lines_issued.
REQ-027 mem_req and mem_addr SHALL stay stable until mem_req_ready is seen.
REQ-028 In WAIT_DATA, on mem_rvalid the block SHALL capture mem_rdata into the hold register and go to DELIVER; mem_rvalid in any other state SHALL be ignored.
REQ-029 buf_base SHALL be the first offset on the first line and 0 otherwise.
REQ-030 buf_bounds SHALL be the last end offset on the last line and MAX_ELEMS otherwise.
REQ-031 A single-line request SHALL use both the first offset and the last end offset.
REQ-032 In DELIVER, buf_load SHALL be asserted for exactly one cycle, in the first cycle buf_busy is 0; buf_data, buf_base and buf_bounds SHALL be valid in that cycle.
REQ-033 After buf_load, if cur_line == last_line the FSM SHALL go to IDLE with done = 1 for one cycle; otherwise it SHALL increment cur_line and go to ISSUE.
REQ-034 At most one memory read SHALL be outstanding.
REQ-035 Line arithmetic SHALL be IDX_WIDTH unsigned; req_end = 2^IDX_WIDTH-1 SHALL NOT overflow cur_line.
REQ-036 buf_load SHALL never be asserted while buf_busy is 1.

Reset
REQ-037 While rst_n = 0, the FSM SHALL be in IDLE and req_ready = 1; mem_req, buf_load and done SHALL be 0; lines_issued, buf_base and buf_data SHALL be 0; buf_bounds SHALL be 0.
REQ-038 Reset asserted mid-operation SHALL abandon the request; a late mem_rvalid after reset SHALL be ignored.

Verification
REQ-039 Request start=3, end=6 -> one read at addr 0; buf_base=3, buf_bounds=6; done one cycle after buf_load.
REQ-040 Request start=5, end=21 -> reads at addr 0, 1, 2; (base, bounds) = (5,8), (0,8), (0,5); lines_issued += 3.
REQ-041 Request start=8, end=8 -> no mem_req; done pulses next cycle.
REQ-042 Hold buf_busy=1 for 10 cycles in DELIVER, then drop it -> buf_load asserts only in the first cycle buf_busy=0.
REQ-043 Hold mem_req_ready=0 for 5 cycles -> mem_req and mem_addr stay stable; lines_issued increments once.
REQ-044 Assert rst_n=0 in WAIT_DATA, then deassert it and send mem_rvalid -> no buf_load, state IDLE, req_ready=1.
